// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code decoder: default width and
// width-bounded Gray/binary conversion helpers (valid for width <= GRAY_FN_WIDTH).
package gray_pkg;

    localparam int unsigned DEFAULT_GRAY_WIDTH = 4;
    localparam int unsigned GRAY_FN_WIDTH      = 32;

    function automatic logic [GRAY_FN_WIDTH-1:0] gray2bin(
        input logic [GRAY_FN_WIDTH-1:0] g,
        input int unsigned              width
    );
        logic [GRAY_FN_WIDTH-1:0] b;
        logic                     acc;
        int unsigned              idx;
        b   = '0;
        acc = 1'b0;
        for (int unsigned k = 0; k < width && k < GRAY_FN_WIDTH; k++) begin
            idx    = width - 1 - k;
            acc    = acc ^ g[idx];
            b[idx] = acc;
        end
        return b;
    endfunction

    function automatic logic [GRAY_FN_WIDTH-1:0] bin2gray(
        input logic [GRAY_FN_WIDTH-1:0] b,
        input int unsigned              width
    );
        logic [GRAY_FN_WIDTH-1:0] mask;
        mask = (width >= GRAY_FN_WIDTH) ? '1 : ((32'd1 << width) - 32'd1);
        return (b ^ (b >> 1)) & mask;
    endfunction

endpackage

// File: rtl/gray_step_checker.sv
// Flags valid Gray samples that differ from the previous valid sample in
// more than one bit; used by gray_to_binary under GRAY_TO_BINARY_STEP_CHECK_EN.
module gray_step_checker
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_GRAY_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray,
    input  logic             in_valid,
    output logic             step_err,
    output logic             step_err_sticky
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] prev;
    logic             have_hist;
    logic [CW-1:0]    diff_bits;
    logic             multi_bit;

    always_comb begin
        diff_bits = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            diff_bits = diff_bits + CW'(prev[i] ^ gray[i]);
        end
        // Without history the first sample after reset is always legal.
        multi_bit = have_hist && (diff_bits > CW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev            <= '0;
            have_hist       <= 1'b0;
            step_err        <= 1'b0;
            step_err_sticky <= 1'b0;
        end else begin
            step_err <= in_valid && multi_bit;
            if (in_valid) begin
                prev      <= gray;
                have_hist <= 1'b1;
            end
            if (in_valid && multi_bit) begin
                step_err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gray_to_binary.sv
// Gray-to-binary decoder: combinational decode plus a registered copy with
// valid strobe. Define GRAY_TO_BINARY_STEP_CHECK_EN to build the step checker.
module gray_to_binary
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_GRAY_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray,
    input  logic             in_valid,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] binary_q,
    output logic             out_valid,
    output logic             step_err,
    output logic             step_err_sticky
);

    // binary[i] is the XOR of gray[WIDTH-1:i].
    always_comb begin
        binary = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            binary[i] = ^(gray >> i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            binary_q  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                binary_q <= binary;
            end
        end
    end

`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
    gray_step_checker #(
        .WIDTH(WIDTH)
    ) u_step_checker (
        .clk            (clk),
        .rst_n          (rst_n),
        .gray           (gray),
        .in_valid       (in_valid),
        .step_err       (step_err),
        .step_err_sticky(step_err_sticky)
    );
`else
    assign step_err        = 1'b0;
    assign step_err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_gray_to_binary.sv
// Self-checking bench for gray_to_binary (WIDTH 4, 1 and 8) using a queue
// scoreboard for the registered path and step checker.
module tb_gray_to_binary;
    import gray_pkg::*;

`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] gray;
    logic       in_valid;
    logic [3:0] binary, binary_q;
    logic       out_valid, step_err, step_err_sticky;

    logic [0:0] gray1, b1, b1q;
    logic       ov1, se1, ss1;
    logic [7:0] gray8, b8, b8q;
    logic       ov8, se8, ss8;

    always #5 clk = ~clk;

    gray_to_binary #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .gray(gray), .in_valid(in_valid),
        .binary(binary), .binary_q(binary_q), .out_valid(out_valid),
        .step_err(step_err), .step_err_sticky(step_err_sticky)
    );

    gray_to_binary #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .gray(gray1), .in_valid(in_valid),
        .binary(b1), .binary_q(b1q), .out_valid(ov1),
        .step_err(se1), .step_err_sticky(ss1)
    );

    gray_to_binary #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .gray(gray8), .in_valid(in_valid),
        .binary(b8), .binary_q(b8q), .out_valid(ov8),
        .step_err(se8), .step_err_sticky(ss8)
    );

    typedef struct packed {
        logic [3:0] bin;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] map4 [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0111, 4'b0110, 4'b0100, 4'b0101,
                              4'b1111, 4'b1110, 4'b1100, 4'b1101,
                              4'b1000, 4'b1001, 4'b1011, 4'b1010};
    logic [3:0] prev_g;
    logic [3:0] held;
    logic       have_hist;
    logic       sticky_exp;
    int         checks = 0;
    int         passes = 0;

    task automatic clear_model();
        exp_q.delete();
        have_hist  = 1'b0;
        sticky_exp = 1'b0;
        held       = '0;
        prev_g     = '0;
    endtask

    // Drive one sample on the falling edge and record its expected result.
    task automatic apply(input logic [3:0] g, input logic v);
        exp_t e;
        @(negedge clk);
        gray     = g;
        in_valid = v;
        if (v) begin
            e.bin = map4[g];
            e.err = CHECK_EN && have_hist && ($countones(g ^ prev_g) > 1);
            exp_q.push_back(e);
            prev_g    = g;
            have_hist = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_sequence(input string name, input logic [4:0] seq [8], input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            apply(seq[i][3:0], seq[i][4]);
            checks++;
            if (exp_q.size() != 0) begin
                e          = exp_q.pop_front();
                held       = e.bin;
                sticky_exp = sticky_exp | e.err;
                if (out_valid !== 1'b1 || binary_q !== e.bin || step_err !== e.err) begin
                    $display("FAIL %s[%0d]: out_valid=%b binary_q=%b step_err=%b, required 1 %b %b",
                             name, i, out_valid, binary_q, step_err, e.bin, e.err);
                end else begin
                    passes++;
                end
            end else begin
                if (out_valid !== 1'b0 || binary_q !== held || step_err !== 1'b0) begin
                    $display("FAIL %s[%0d] idle: out_valid=%b binary_q=%b step_err=%b, required 0 %b 0",
                             name, i, out_valid, binary_q, step_err, held);
                end else begin
                    passes++;
                end
            end
            checks++;
            if (step_err_sticky !== sticky_exp) begin
                $display("FAIL %s[%0d] sticky: got %b, required %b", name, i, step_err_sticky, sticky_exp);
            end else begin
                passes++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        gray     = '0;
        gray1    = '0;
        gray8    = '0;
        in_valid = 1'b0;
        clear_model();
        #3;
        checks++;
        if (binary_q !== 4'b0000 || out_valid !== 1'b0 || step_err !== 1'b0 || step_err_sticky !== 1'b0) begin
            $display("FAIL reset_state: binary_q=%b out_valid=%b step_err=%b sticky=%b, required 0000 0 0 0",
                     binary_q, out_valid, step_err, step_err_sticky);
        end else begin
            passes++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        logic [31:0] g32;
        logic [31:0] want;
        for (int g = 0; g < 16; g++) begin
            gray = 4'(g);
            #1;
            checks++;
            if (binary !== map4[g]) begin
                $display("FAIL decode4 gray=%b: got %b, required %b", gray, binary, map4[g]);
            end else begin
                passes++;
            end
        end
        for (int g = 0; g < 2; g++) begin
            gray1 = 1'(g);
            #1;
            checks++;
            if (b1 !== 1'(g)) begin
                $display("FAIL decode1 gray=%b: got %b, required %b", gray1, b1, 1'(g));
            end else begin
                passes++;
            end
        end
        gray8 = 8'h80;
        #1;
        checks++;
        if (b8 !== 8'hFF) begin
            $display("FAIL decode8 gray=80: got %h, required ff", b8);
        end else begin
            passes++;
        end
        gray8 = 8'hC0;
        #1;
        checks++;
        if (b8 !== 8'h80) begin
            $display("FAIL decode8 gray=c0: got %h, required 80", b8);
        end else begin
            passes++;
        end
        for (int k = 0; k < 6; k++) begin
            g32   = 32'($urandom_range(255));
            gray8 = g32[7:0];
            want  = gray2bin(g32, 8);
            #1;
            checks++;
            if (b8 !== want[7:0]) begin
                $display("FAIL decode8 gray=%h: got %h, required %h", gray8, b8, want[7:0]);
            end else begin
                passes++;
            end
        end
    endtask

    task automatic test_registered();
        exp_t e;
        apply(4'b0110, 1'b1);
        e    = exp_q.pop_front();
        held = e.bin;
        checks++;
        if (out_valid !== 1'b1 || binary_q !== 4'b0100) begin
            $display("FAIL reg_capture: out_valid=%b binary_q=%b, required 1 0100", out_valid, binary_q);
        end else begin
            passes++;
        end
        apply(4'b1001, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || binary_q !== 4'b0100) begin
            $display("FAIL reg_hold: out_valid=%b binary_q=%b, required 0 0100", out_valid, binary_q);
        end else begin
            passes++;
        end
    endtask

    task automatic test_step();
        logic [4:0] s [8];
        s = '{5'b1_0000, 5'b1_0001, 5'b1_0011, 5'b1_0010,
              5'b1_0101, 5'b0_0000, 5'b0_0110, 5'b1_1111};
        run_sequence("step", s, 8);
    endtask

    task automatic test_midstream_reset();
        @(posedge clk);
        #2;
        checks++;
        if (binary_q !== 4'b1010) begin
            $display("FAIL pre_reset binary_q: got %b, required 1010", binary_q);
        end else begin
            passes++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (binary_q !== 4'b0000 || out_valid !== 1'b0 || step_err !== 1'b0 || step_err_sticky !== 1'b0) begin
            $display("FAIL async_reset: binary_q=%b out_valid=%b step_err=%b sticky=%b, required 0000 0 0 0",
                     binary_q, out_valid, step_err, step_err_sticky);
        end else begin
            passes++;
        end
        gray = 4'b0100;
        #1;
        checks++;
        if (binary !== 4'b0111) begin
            $display("FAIL decode_in_reset: got %b, required 0111", binary);
        end else begin
            passes++;
        end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_after_reset();
        logic [4:0] s [8];
        s = '{5'b1_1111, 5'b1_1111, 5'b0_0000, 5'b1_1110,
              5'b1_0000, 5'b0_0000, 5'b0_0000, 5'b0_0000};
        run_sequence("after_reset", s, 5);
    endtask

    task automatic test_back_to_back();
        logic [4:0]  s [8];
        logic [31:0] g;
        logic [31:0] cnt;
        cnt = '0;
        for (int chunk = 0; chunk < 5; chunk++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(5) == 0) begin
                    g = 32'($urandom_range(15));
                end else begin
                    cnt = cnt + 32'd1;
                    g   = bin2gray(cnt, 4);
                end
                s[i] = {($urandom_range(3) != 0), g[3:0]};
            end
            run_sequence("back_to_back", s, 8);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_registered();
        test_step();
        test_midstream_reset();
        test_after_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
